mem_lsu: RTL and testbench

- Load/store unit between the memory stage and the data-memory bus; replaces the single-cycle data RAM behind mem_stage.
- Takes one load or store per instruction and issues a word-aligned ready/valid bus request with byte strobes.
- Formats load data with sign/zero extension and raises a stall to the hazard unit while the access is outstanding.
- Detects misaligned or illegal accesses and bus timeouts.

---
 rtl/mem_lsu.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the memory stage and the data-memory bus.
// Accepts one load or store per instruction, issues a word-aligned
// ready/valid bus request with byte strobes, formats load data, and
// stalls the pipeline while the access is outstanding. Misaligned or
// illegal accesses and bus timeouts complete with err.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   req_*             load/store request from the memory stage
//   stall             combinational hold for IF/ID/EX/MEM
//   rdata/done/err    completion pulse with formatted load data
//   bus_req_*         word-aligned bus request (addr, we, wstrb, wdata)
//   bus_rsp_*         bus response beat (reads and writes both respond)
module mem_lsu #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [31:0]       addr_r;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [3:0]        wstrb_r;
    logic [31:0]       wdata_r;
    logic [31:0]       rdata_r;
    logic              err_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              legal_s;
    logic              timeout_s;
    logic              stall_s;
    logic              finish_s;
    logic              fail_s;

    // Access is legal when funct3 names a real load/store and the address
    // is naturally aligned for its size.
    function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] lane);
        logic ok;
        case (f3)
            3'b000, 3'b100: ok = 1'b1;
            3'b001, 3'b101: ok = ~lane[0];
            3'b010:         ok = (lane == 2'b00);
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables for a store of the given size at the given lane.
    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] s;
        case (size)
            2'b00:   s = 4'b0001 << lane;
            2'b01:   s = 4'b0011 << {lane[1], 1'b0};
            2'b10:   s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Store data replicated across all lanes so the strobes pick the slot.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            2'b10:   w = d;
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Select the addressed byte/halfword and sign- or zero-extend it.
    function automatic logic [31:0] load_format(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'h00_0000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign legal_s   = access_legal(req_funct3, req_addr[1:0]);
    // Greater-or-equal so a handshake landing on the last cycle cannot let
    // the counter run past the limit and wrap.
    assign timeout_s = (cnt_r >= CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, stall and completion decode.
    always_comb begin
        state_s  = state_r;
        stall_s  = 1'b0;
        finish_s = 1'b0;
        fail_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    if (legal_s) begin
                        stall_s = 1'b1;
                        state_s = S_REQ;
                    end else begin
                        finish_s = 1'b1;
                        fail_s   = 1'b1;
                        state_s  = S_DONE;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                stall_s = 1'b1;
                if (bus_req_ready) begin
                    state_s = S_WAIT;
                end else if (timeout_s) begin
                    finish_s = 1'b1;
                    fail_s   = 1'b1;
                    state_s  = S_DONE;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                stall_s = 1'b1;
                if (bus_rsp_valid) begin
                    finish_s = 1'b1;
                    state_s  = S_DONE;
                end else if (timeout_s) begin
                    finish_s = 1'b1;
                    fail_s   = 1'b1;
                    state_s  = S_DONE;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request latch, timeout counter and completion result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r   <= 32'h0000_0000;
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            wstrb_r  <= 4'b0000;
            wdata_r  <= 32'h0000_0000;
            rdata_r  <= 32'h0000_0000;
            err_r    <= 1'b0;
            cnt_r    <= '0;
        end else begin
            if (state_r == S_IDLE && req_valid) begin
                addr_r   <= req_addr;
                we_r     <= req_we;
                funct3_r <= req_funct3;
                wstrb_r  <= req_we ? store_strb(req_funct3[1:0], req_addr[1:0]) : 4'b0000;
                wdata_r  <= req_we ? store_data(req_funct3[1:0], req_wdata) : 32'h0000_0000;
            end
            if (state_r != S_REQ && state_s == S_REQ) begin
                cnt_r <= '0;
            end else if (state_r == S_REQ || state_r == S_WAIT) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (finish_s) begin
                err_r   <= fail_s;
                rdata_r <= (fail_s || we_r) ? 32'h0000_0000
                                            : load_format(funct3_r, addr_r[1:0], bus_rdata);
            end
        end
    end

    assign stall         = stall_s;
    assign done          = (state_r == S_DONE);
    assign err           = (state_r == S_DONE) && err_r;
    assign rdata         = rdata_r;
    assign bus_req_valid = (state_r == S_REQ);
    assign bus_we        = (state_r == S_REQ) && we_r;
    assign bus_addr      = {addr_r[31:2], 2'b00};
    assign bus_wstrb     = (state_r == S_REQ) ? wstrb_r : 4'b0000;
    assign bus_wdata     = wdata_r;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: stimulus pushes expected bus requests and
// completions into queues; a monitor pops and compares them as the DUT
// presents handshakes and done pulses. A bus responder model supplies
// ready (with programmable delay) and a response one cycle after accept.
module tb_mem_lsu;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rdata;

    int          n_cmp = 0;
    int          n_bad = 0;
    bus_t        exp_bus[$];
    logic [32:0] exp_cmp[$];

    int          ready_delay = 0;
    logic        rsp_en = 1'b1;
    logic [31:0] rsp_data = 32'h0;
    logic        inject_rsp = 1'b0;

    mem_lsu #(.TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rdata(rdata), .done(done), .err(err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
        .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus responder: ready after ready_delay REQ cycles, response the cycle after accept.
    initial begin
        logic hs;
        int   wcnt;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rdata     = 32'h0;
        wcnt          = 0;
        forever begin
            @(negedge clk);
            hs = bus_req_valid && bus_req_ready;
            @(posedge clk);
            #1;
            bus_rsp_valid = (hs && rsp_en) || inject_rsp;
            bus_rdata     = (hs || inject_rsp) ? rsp_data : 32'h0;
            if (bus_req_valid) begin
                bus_req_ready = (wcnt >= ready_delay);
                wcnt++;
            end else begin
                bus_req_ready = 1'b0;
                wcnt          = 0;
            end
        end
    end

    // Monitor: compares handshakes and completions against the scoreboard.
    initial begin
        logic  pv;
        bus_t  prev;
        bus_t  cur;
        bus_t  e;
        logic [32:0] c;
        pv = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = '{addr: bus_addr, we: bus_we, wstrb: bus_wstrb, wdata: bus_wdata};
            if (bus_req_valid) begin
                if (pv) check("bus fields stable", 64'(cur), 64'(prev));
                if (bus_req_ready) begin
                    if (exp_bus.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected bus request: got addr %0h expected none", bus_addr);
                    end else begin
                        e = exp_bus.pop_front();
                        check("bus_addr", 64'(bus_addr), 64'(e.addr));
                        check("bus_we", 64'(bus_we), 64'(e.we));
                        check("bus_wstrb", 64'(bus_wstrb), 64'(e.wstrb));
                        if (e.we) check("bus_wdata", 64'(bus_wdata), 64'(e.wdata));
                    end
                end
            end
            pv   = bus_req_valid && !bus_req_ready;
            prev = cur;
            if (done) begin
                if (exp_cmp.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected done: got done=1 expected none (rdata %0h)", rdata);
                end else begin
                    c = exp_cmp.pop_front();
                    check("err", 64'(err), 64'(c[32]));
                    check("rdata", 64'(rdata), 64'(c[31:0]));
                end
            end else if (err) begin
                n_cmp++;
                n_bad++;
                $display("FAIL err without done: got err=1 expected 0");
            end
        end
    end

    // Issue one access, count stall cycles and time to done.
    task automatic xact(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_stall, input int exp_done_at, input int exp_lat);
        int cyc, nstall, first_req, done_at;
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        cyc = 0; nstall = 0; first_req = -1; done_at = -1;
        while (done_at < 0 && cyc < 100) begin
            @(negedge clk);
            if (stall) nstall++;
            if (bus_req_valid && first_req < 0) first_req = cyc;
            if (done) done_at = cyc;
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            cyc++;
        end
        check({name, " stall cycles"}, 64'(nstall), 64'(exp_stall));
        check({name, " done cycle"}, 64'(done_at), 64'(exp_done_at));
        if (exp_lat >= 0) check({name, " req-to-done"}, 64'(done_at - first_req), 64'(exp_lat));
    endtask

    task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] s, input logic [31:0] d);
        exp_bus.push_back('{addr: a, we: we, wstrb: s, wdata: d});
    endtask

    task automatic push_cmp(input logic e, input logic [31:0] d);
        exp_cmp.push_back({e, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset outputs", 64'({stall, done, err, bus_req_valid, bus_we, bus_wstrb, rdata}), 64'h0);

        // LW minimum latency
        rsp_data = 32'hDEAD_BEEF;
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0); push_cmp(1'b0, 32'hDEAD_BEEF);
        xact("LW", 1'b0, 3'b010, 32'h100, 32'h0, 3, 3, 2);

        // Byte/halfword loads on 0x80FF0000
        rsp_data = 32'h80FF_0000;
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0); push_cmp(1'b0, 32'hFFFF_FF80);
        xact("LB", 1'b0, 3'b000, 32'h103, 32'h0, 3, 3, -1);
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0); push_cmp(1'b0, 32'h0000_0080);
        xact("LBU", 1'b0, 3'b100, 32'h103, 32'h0, 3, 3, -1);
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0); push_cmp(1'b0, 32'h0000_80FF);
        xact("LHU", 1'b0, 3'b101, 32'h102, 32'h0, 3, 3, -1);
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0); push_cmp(1'b0, 32'hFFFF_80FF);
        xact("LH hi", 1'b0, 3'b001, 32'h102, 32'h0, 3, 3, -1);
        rsp_data = 32'h1234_ABCD;
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0); push_cmp(1'b0, 32'hFFFF_ABCD);
        xact("LH lo", 1'b0, 3'b001, 32'h100, 32'h0, 3, 3, -1);
        push_bus(32'h100, 1'b0, 4'b0000, 32'h0); push_cmp(1'b0, 32'h0000_00AB);
        xact("LBU 1", 1'b0, 3'b100, 32'h101, 32'h0, 3, 3, -1);

        // Stores: rdata must come back 0 even with nonzero bus read data
        rsp_data = 32'hFFFF_FFFF;
        push_bus(32'h200, 1'b1, 4'b1000, 32'hA5A5_A5A5); push_cmp(1'b0, 32'h0);
        xact("SB", 1'b1, 3'b000, 32'h203, 32'h0000_00A5, 3, 3, -1);
        push_bus(32'h200, 1'b1, 4'b1100, 32'hBEEF_BEEF); push_cmp(1'b0, 32'h0);
        xact("SH", 1'b1, 3'b001, 32'h202, 32'h1234_BEEF, 3, 3, -1);
        push_bus(32'h300, 1'b1, 4'b1111, 32'hCAFE_F00D); push_cmp(1'b0, 32'h0);
        xact("SW", 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 3, 3, -1);

        // Illegal accesses: no bus traffic, err pulse next cycle
        push_cmp(1'b1, 32'h0);
        xact("LH misaligned", 1'b0, 3'b001, 32'h101, 32'h0, 0, 1, -1);
        push_cmp(1'b1, 32'h0);
        xact("LW misaligned", 1'b0, 3'b010, 32'h102, 32'h0, 0, 1, -1);
        push_cmp(1'b1, 32'h0);
        xact("funct3 011", 1'b0, 3'b011, 32'h0, 32'h0, 0, 1, -1);
        push_cmp(1'b1, 32'h0);
        xact("SW misaligned", 1'b1, 3'b010, 32'h301, 32'h1, 0, 1, -1);

        // Ready held low 5 cycles
        ready_delay = 5; rsp_data = 32'h55AA_55AA;
        push_bus(32'h400, 1'b0, 4'b0000, 32'h0); push_cmp(1'b0, 32'h55AA_55AA);
        xact("LW ready late", 1'b0, 3'b010, 32'h400, 32'h0, 8, 8, -1);
        ready_delay = 0;

        // Timeout: accepted but never answered
        rsp_en = 1'b0;
        push_bus(32'h500, 1'b0, 4'b0000, 32'h0); push_cmp(1'b1, 32'h0);
        xact("timeout", 1'b0, 3'b010, 32'h500, 32'h0, 9, 9, 8);

        // Reset while in WAIT, then a late response must not complete anything
        rsp_data = 32'h1111_2222;
        push_bus(32'h600, 1'b0, 4'b0000, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h600;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post-reset outputs", 64'({stall, done, err, bus_req_valid, bus_we, bus_wstrb, rdata}), 64'h0);
        @(posedge clk); #1;
        inject_rsp = 1'b1;
        @(posedge clk); #1;
        inject_rsp = 1'b0;
        repeat (4) @(negedge clk);
        check("late rsp idle", 64'({stall, bus_req_valid}), 64'h0);
        rsp_en = 1'b1;

        // Functional check after reset
        rsp_data = 32'h0BAD_F00D;
        push_bus(32'h700, 1'b0, 4'b0000, 32'h0); push_cmp(1'b0, 32'h0BAD_F00D);
        xact("LW after reset", 1'b0, 3'b010, 32'h700, 32'h0, 3, 3, 2);

        repeat (3) @(negedge clk);
        check("bus queue drained", 64'(exp_bus.size()), 64'h0);
        check("cmp queue drained", 64'(exp_cmp.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
